// File: rtl/mem_access_unit.sv
// Serial data-memory access unit: splits CPU byte/half/word loads and stores into
// consecutive little-endian SRAM byte accesses while stalling the memory stage.
module mem_access_unit #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              misaligned,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_we,
    output logic [7:0]        sram_wdata,
    input  logic [7:0]        sram_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_r;
    logic [1:0]          cnt_r;
    logic [ADDR_W-1:0]   addr_r;
    logic                we_r;
    logic [1:0]          size_r;
    logic                unsigned_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [31:0]         buf_r;
    logic [DATA_W-1:0]   rdata_r;
    logic                rdata_valid_r;

    logic                req_ok_s;
    logic                accept_s;
    logic                reject_s;
    logic                xfer_s;
    logic                last_s;
    logic [31:0]         buf_next_s;

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lsb);
        logic ok;
        case (size)
            2'b00:   ok = 1'b1;
            2'b01:   ok = (lsb[0] == 1'b0);
            2'b10:   ok = (lsb == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [1:0] last_index(input logic [1:0] size);
        logic [1:0] idx;
        case (size)
            2'b00:   idx = 2'd0;
            2'b01:   idx = 2'd1;
            2'b10:   idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] b, input logic [1:0] size,
                                                input logic uns);
        logic [31:0] res;
        case (size)
            2'b00:   res = {{24{~uns & b[7]}}, b[7:0]};
            2'b01:   res = {{16{~uns & b[15]}}, b[15:0]};
            default: res = b;
        endcase
        return res;
    endfunction

    // Request decode, SRAM port steering and the combinational stall/reject lines.
    always_comb begin
        req_ok_s   = is_aligned(req_size, req_addr[1:0]);
        accept_s   = (state_r == IDLE) && req_valid && req_ok_s;
        reject_s   = (state_r == IDLE) && req_valid && !req_ok_s;
        xfer_s     = (state_r == XFER);
        last_s     = (cnt_r == last_index(size_r));
        stall      = xfer_s || accept_s;
        misaligned = reject_s;
        sram_we    = xfer_s && we_r;
        sram_addr  = xfer_s ? (addr_r + {{(ADDR_W-2){1'b0}}, cnt_r}) : req_addr;
        buf_next_s = buf_r;
        case (cnt_r)
            2'd0: begin
                sram_wdata       = wdata_r[7:0];
                buf_next_s[7:0]  = sram_rdata;
            end
            2'd1: begin
                sram_wdata       = wdata_r[15:8];
                buf_next_s[15:8] = sram_rdata;
            end
            2'd2: begin
                sram_wdata        = wdata_r[23:16];
                buf_next_s[23:16] = sram_rdata;
            end
            2'd3: begin
                sram_wdata        = wdata_r[31:24];
                buf_next_s[31:24] = sram_rdata;
            end
            default: begin
                sram_wdata = 8'h00;
            end
        endcase
    end

    // Transfer sequencer; the load result is assembled on the last XFER edge so it
    // is already valid, together with its pulse, throughout the DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            cnt_r         <= 2'd0;
            addr_r        <= {ADDR_W{1'b0}};
            we_r          <= 1'b0;
            size_r        <= 2'b00;
            unsigned_r    <= 1'b0;
            wdata_r       <= {DATA_W{1'b0}};
            buf_r         <= 32'h0000_0000;
            rdata_r       <= {DATA_W{1'b0}};
            rdata_valid_r <= 1'b0;
        end else begin
            rdata_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        addr_r     <= req_addr;
                        we_r       <= req_we;
                        size_r     <= req_size;
                        unsigned_r <= req_unsigned;
                        wdata_r    <= req_wdata;
                        cnt_r      <= 2'd0;
                        state_r    <= XFER;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                XFER: begin
                    if (!we_r) begin
                        buf_r <= buf_next_s;
                    end else begin
                        buf_r <= buf_r;
                    end
                    if (last_s) begin
                        state_r <= DONE;
                        if (!we_r) begin
                            rdata_r       <= extend_load(buf_next_s, size_r, unsigned_r);
                            rdata_valid_r <= 1'b1;
                        end else begin
                            rdata_r       <= rdata_r;
                        end
                    end else begin
                        cnt_r <= cnt_r + 2'd1;
                    end
                end
                DONE: begin
                    cnt_r   <= 2'd0;
                    state_r <= IDLE;
                end
                default: begin
                    cnt_r   <= 2'd0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign rdata       = rdata_r;
    assign rdata_valid = rdata_valid_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit with a transaction-level reference model
// and a byte-wide SRAM environment.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        misaligned;
    logic [15:0] sram_addr;
    logic        sram_we;
    logic [7:0]  sram_wdata;
    logic [7:0]  sram_rdata;

    logic [7:0]  sram    [0:65535];
    logic [7:0]  ref_mem [0:65535];

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int stall_cnt = 0;
    int mis_cnt   = 0;
    int pulse_q[$];

    bit          chk_en = 1'b0;
    logic        exp_stall, exp_mis, exp_rv, exp_we;
    logic [15:0] exp_addr;
    logic [7:0]  exp_wdata;
    logic [31:0] model_rdata;

    mem_access_unit #(.ADDR_W(16), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
        .misaligned(misaligned), .sram_addr(sram_addr), .sram_we(sram_we),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    assign sram_rdata = sram[sram_addr];

    always @(posedge clk) begin
        if (sram_we) sram[sram_addr] <= sram_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Per-cycle comparison against the model's expectations.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", {31'd0, stall}, {31'd0, exp_stall});
            chk("misaligned", {31'd0, misaligned}, {31'd0, exp_mis});
            chk("rdata_valid", {31'd0, rdata_valid}, {31'd0, exp_rv});
            chk("rdata", rdata, model_rdata);
            chk("sram_we", {31'd0, sram_we}, {31'd0, exp_we});
            chk("sram_addr", {16'd0, sram_addr}, {16'd0, exp_addr});
            if (exp_we) chk("sram_wdata", {24'd0, sram_wdata}, {24'd0, exp_wdata});
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (stall === 1'b1) stall_cnt++;
        if (misaligned === 1'b1) mis_cnt++;
        if (rdata_valid === 1'b1) pulse_q.push_back(cyc);
    end

    task automatic scramble();
        req_valid    = 1'($urandom_range(0, 1));
        req_we       = 1'($urandom_range(0, 1));
        req_size     = 2'($urandom_range(0, 3));
        req_unsigned = 1'($urandom_range(0, 1));
        req_addr     = 16'($urandom);
        req_wdata    = $urandom;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_addr  = 16'($urandom);
        exp_stall = 1'b0; exp_mis = 1'b0; exp_rv = 1'b0; exp_we = 1'b0;
        exp_addr  = req_addr;
        @(posedge clk); #1;
    endtask

    // One CPU request from its request cycle through DONE; optional reset after
    // rst_after completed XFER cycles (negative = none).
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [15:0] addr, input logic [31:0] wd,
                          input bit noisy, input int rst_after);
        bit ok;
        int n;
        logic [63:0] v;
        logic [15:0] a;
        ok = (size == 2'd0) || (size == 2'd1 && addr[0] == 1'b0) ||
             (size == 2'd2 && addr[1:0] == 2'd0);
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        exp_stall = ok; exp_mis = !ok; exp_rv = 1'b0; exp_we = 1'b0; exp_addr = addr;
        @(posedge clk); #1;
        if (!ok) return;
        v = 64'd0;
        for (int i = 0; i < n; i++) begin
            a = addr + 16'(i);
            v = v | (64'(ref_mem[a]) << (8 * i));
        end
        for (int k = 1; k <= n; k++) begin
            if (rst_after >= 0 && k > rst_after) begin
                rst = 1'b1;
                req_valid = 1'b0;
                model_rdata = 32'd0;
                exp_stall = 1'b0; exp_mis = 1'b0; exp_rv = 1'b0; exp_we = 1'b0;
                exp_addr = req_addr;
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            if (noisy) scramble();
            a = addr + 16'(k - 1);
            exp_stall = 1'b1; exp_mis = 1'b0; exp_rv = 1'b0; exp_we = we;
            exp_addr = a;
            exp_wdata = wd[8*(k-1) +: 8];
            if (we) ref_mem[a] = exp_wdata;
            @(posedge clk); #1;
        end
        if (noisy) scramble();
        exp_stall = 1'b0; exp_mis = 1'b0; exp_we = 1'b0; exp_addr = req_addr;
        if (!we) begin
            if (!uns && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
            model_rdata = v[31:0];
            exp_rv = 1'b1;
        end else begin
            exp_rv = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int bad;
        int first_bad;
        logic [7:0] old22, old23;
        logic        r_we, r_uns;
        logic [1:0]  r_size;
        logic [15:0] r_addr;
        int          r_rst, gap;

        for (int i = 0; i < 65536; i++) begin
            sram[i]    = 8'($urandom);
            ref_mem[i] = sram[i];
        end
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 16'h0000; req_wdata = 32'd0;
        model_rdata = 32'd0;
        exp_stall = 1'b0; exp_mis = 1'b0; exp_rv = 1'b0; exp_we = 1'b0;
        exp_addr = 16'h0000; exp_wdata = 8'h00;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle();

        // Word store / word load round trip.
        stall_cnt = 0;
        do_req(1'b1, 2'd2, 1'b0, 16'h8000, 32'hDEADBEEF, 1'b0, -1);
        idle();
        chk("word_store_stall_cycles", stall_cnt, 32'd5);
        chk("sram_8000", {24'd0, sram[16'h8000]}, 32'h0000_00EF);
        chk("sram_8001", {24'd0, sram[16'h8001]}, 32'h0000_00BE);
        chk("sram_8002", {24'd0, sram[16'h8002]}, 32'h0000_00AD);
        chk("sram_8003", {24'd0, sram[16'h8003]}, 32'h0000_00DE);
        stall_cnt = 0;
        do_req(1'b0, 2'd2, 1'b0, 16'h8000, 32'd0, 1'b0, -1);
        idle();
        chk("word_load_stall_cycles", stall_cnt, 32'd5);
        chk("word_load_value", rdata, 32'hDEADBEEF);

        // Byte loads, signed and unsigned.
        stall_cnt = 0;
        do_req(1'b0, 2'd0, 1'b0, 16'h8003, 32'd0, 1'b0, -1);
        idle();
        chk("byte_load_signed", rdata, 32'hFFFFFFDE);
        chk("byte_load_stall_cycles", stall_cnt, 32'd2);
        do_req(1'b0, 2'd0, 1'b1, 16'h8003, 32'd0, 1'b0, -1);
        idle();
        chk("byte_load_unsigned", rdata, 32'h000000DE);

        // Half store / half load.
        stall_cnt = 0;
        do_req(1'b1, 2'd1, 1'b0, 16'h8010, 32'h00001234, 1'b0, -1);
        idle();
        chk("half_store_stall_cycles", stall_cnt, 32'd3);
        chk("sram_8010", {24'd0, sram[16'h8010]}, 32'h0000_0034);
        chk("sram_8011", {24'd0, sram[16'h8011]}, 32'h0000_0012);
        do_req(1'b0, 2'd1, 1'b0, 16'h8010, 32'd0, 1'b0, -1);
        idle();
        chk("half_load_value", rdata, 32'h00001234);

        // Rejected requests.
        stall_cnt = 0; mis_cnt = 0;
        do_req(1'b0, 2'd2, 1'b0, 16'h8002, 32'd0, 1'b0, -1);
        do_req(1'b0, 2'd1, 1'b0, 16'h8001, 32'd0, 1'b0, -1);
        do_req(1'b1, 2'd3, 1'b0, 16'h8000, 32'h11223344, 1'b0, -1);
        idle();
        chk("misaligned_stall_cycles", stall_cnt, 32'd0);
        chk("misaligned_pulses", mis_cnt, 32'd3);
        chk("sram_8000_after_reject", {24'd0, sram[16'h8000]}, 32'h0000_00EF);

        // Reset in the middle of a word store.
        old22 = ref_mem[16'h8022];
        old23 = ref_mem[16'h8023];
        do_req(1'b1, 2'd2, 1'b0, 16'h8020, 32'hAABBCCDD, 1'b0, 2);
        chk("rst_sram_8020", {24'd0, sram[16'h8020]}, 32'h0000_00DD);
        chk("rst_sram_8021", {24'd0, sram[16'h8021]}, 32'h0000_00CC);
        chk("rst_sram_8022", {24'd0, sram[16'h8022]}, {24'd0, old22});
        chk("rst_sram_8023", {24'd0, sram[16'h8023]}, {24'd0, old23});
        chk("rst_rdata", rdata, 32'd0);
        idle();

        // Back-to-back byte loads with req_valid held high.
        pulse_q.delete();
        do_req(1'b0, 2'd0, 1'b1, 16'h8000, 32'd0, 1'b0, -1);
        do_req(1'b0, 2'd0, 1'b1, 16'h8001, 32'd0, 1'b0, -1);
        idle();
        chk("b2b_pulse_count", pulse_q.size(), 32'd2);
        if (pulse_q.size() == 2) chk("b2b_pulse_spacing", pulse_q[1] - pulse_q[0], 32'd3);
        chk("b2b_last_value", rdata, 32'h000000BE);

        // Randomized traffic.
        for (int t = 0; t < 400; t++) begin
            r_we   = 1'($urandom_range(0, 1));
            r_uns  = 1'($urandom_range(0, 1));
            r_size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) r_addr = 16'hFFFC + 16'($urandom_range(0, 3));
            else r_addr = 16'h8000 + 16'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) r_addr[1:0] = 2'b00;
            r_rst = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 3)) : -1;
            do_req(r_we, r_size, r_uns, r_addr, $urandom, 1'($urandom_range(0, 1)), r_rst);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) idle();
        end
        idle();

        bad = 0;
        first_bad = -1;
        for (int i = 0; i < 65536; i++) begin
            if (sram[i] !== ref_mem[i]) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        chk("sram_image_mismatches", bad, 32'd0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
